// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command issue stage.
// The command word is {a, b, op}, 20 bits wide.
package alu_pkg;

  localparam int ALU_W = 8;

  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_OR   = 4'h1;
  localparam logic [3:0] OP_XOR  = 4'h2;
  localparam logic [3:0] OP_NAND = 4'h3;
  localparam logic [3:0] OP_NOR  = 4'h4;
  localparam logic [3:0] OP_XNOR = 4'h5;
  localparam logic [3:0] OP_ADD  = 4'h6;
  localparam logic [3:0] OP_SUB  = 4'h7;
  localparam logic [3:0] OP_MUL  = 4'h8;
  localparam logic [3:0] OP_DIV  = 4'h9;
  localparam logic [3:0] OP_SHL  = 4'hA;
  localparam logic [3:0] OP_SHR  = 4'hB;
  localparam logic [3:0] OP_ROR  = 4'hC;
  localparam logic [3:0] OP_ROL  = 4'hD;
  localparam logic [3:0] OP_EQ   = 4'hE;
  localparam logic [3:0] OP_GT   = 4'hF;

  typedef struct packed {
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    logic [3:0]       op;
  } alu_cmd_t;

  localparam int CMD_W = $bits(alu_cmd_t);

  typedef enum logic {
    R_EMPTY = 1'b0,
    R_FULL  = 1'b1
  } rsp_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with occupancy count and synchronous flush.
// Pointers wrap modulo DEPTH; the count alone separates full from empty.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 20,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign push_ok = push && !flush && (count_q != CW'(DEPTH));
  assign pop_ok  = pop && !flush && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(push_ok);
      rd_ptr_d = rd_ptr_q + AW'(pop_ok);
      count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; an empty FIFO's head is masked by the consumer.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/alu_cmd_issue.sv
// Command issue / result capture around a combinational 8-bit ALU.
// Commands queue in a FIFO; the head feeds the ALU and its result is registered.
//
// state   | meaning
// R_EMPTY | result register holds nothing
// R_FULL  | result register holds a result awaiting rsp_ready
module alu_cmd_issue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [ALU_W-1:0] cmd_a,
  input  logic [ALU_W-1:0] cmd_b,
  input  logic [3:0]       cmd_op,
  output logic [ALU_W-1:0] alu_a,
  output logic [ALU_W-1:0] alu_b,
  output logic [3:0]       alu_opcode,
  input  logic [ALU_W-1:0] alu_out,
  input  logic             alu_c_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [ALU_W-1:0] rsp_data,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_div0,
  output logic [CW-1:0]    fifo_count
);

  alu_cmd_t         wr_cmd, head;
  logic [CW-1:0]    count_w;
  logic             head_vld, push, pop, capture, div0_hit;
  rsp_state_e       state_q, state_d;
  logic [ALU_W-1:0] data_q, data_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             div0_q, div0_d;

  // Ready looks only at registered occupancy, so a full FIFO never accepts.
  assign cmd_ready = (count_w < CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready && !flush;
  assign head_vld  = (count_w != '0);

  assign wr_cmd.a  = cmd_a;
  assign wr_cmd.b  = cmd_b;
  assign wr_cmd.op = cmd_op;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (wr_cmd),
    .rdata (head),
    .count (count_w)
  );

  assign alu_a      = head_vld ? head.a  : '0;
  assign alu_b      = head_vld ? head.b  : '0;
  assign alu_opcode = head_vld ? head.op : '0;
  assign div0_hit   = (alu_opcode == OP_DIV) && (alu_b == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= R_EMPTY;
      data_q  <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      div0_q  <= div0_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = R_EMPTY;
    end else begin
      unique case (state_q)
        R_EMPTY: if (head_vld) state_d = R_FULL;
        R_FULL:  if (rsp_ready && !head_vld) state_d = R_EMPTY;
        default: state_d = R_EMPTY;
      endcase
    end
  end

  // Flush wins over capture; a consumed slot can be refilled in the same cycle.
  always_comb begin
    capture = head_vld && !flush && ((state_q == R_EMPTY) || rsp_ready);
    pop     = capture;
    data_d  = data_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    div0_d  = div0_q;
    if (capture) begin
      if (div0_hit) begin
        data_d  = '1;
        carry_d = 1'b0;
        div0_d  = 1'b1;
      end else begin
        data_d  = alu_out;
        carry_d = alu_c_out;
        div0_d  = 1'b0;
      end
      zero_d = (data_d == '0);
    end
  end

  assign rsp_valid  = (state_q == R_FULL);
  assign rsp_data   = data_q;
  assign rsp_carry  = carry_q;
  assign rsp_zero   = zero_q;
  assign rsp_div0   = div0_q;
  assign fifo_count = count_w;

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Directed bench for alu_cmd_issue: supplies a behavioural ALU and checks
// results through a scoreboard queue plus directed point checks.
module tb_alu_cmd_issue;

  logic       clk = 1'b0;
  logic       rst_n, flush, cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic [7:0] cmd_a, cmd_b, alu_a, alu_b, alu_out, rsp_data;
  logic [3:0] cmd_op, alu_opcode;
  logic       alu_c_out, rsp_carry, rsp_zero, rsp_div0;
  logic [2:0] fifo_count;

  typedef struct packed {
    logic [7:0] d;
    logic       c;
    logic       z;
    logic       v0;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   passes = 0;
  int   accepted = 0;

  always #5 clk = ~clk;

  alu_cmd_issue #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_out    (alu_out),
    .alu_c_out  (alu_c_out),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_carry  (rsp_carry),
    .rsp_zero   (rsp_zero),
    .rsp_div0   (rsp_div0),
    .fifo_count (fifo_count)
  );

  // Behavioural ALU; divide by zero returns junk so the DUT override is visible.
  function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] op);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (op)
      4'h0: return {1'b0, a & b};
      4'h1: return {1'b0, a | b};
      4'h2: return {1'b0, a ^ b};
      4'h3: return {1'b0, ~(a & b)};
      4'h4: return {1'b0, ~(a | b)};
      4'h5: return {1'b0, ~(a ^ b)};
      4'h6: return {1'b0, a} + {1'b0, b};
      4'h7: return {1'b0, a} - {1'b0, b};
      4'h8: return p[8:0];
      4'h9: return (b == 8'h00) ? 9'h15A : {1'b0, a / b};
      4'hA: return {a, 1'b0};
      4'hB: return {1'b0, 1'b0, a[7:1]};
      4'hC: return {1'b0, a[0], a[7:1]};
      4'hD: return {1'b0, a[6:0], a[7]};
      4'hE: return {8'h00, a == b};
      default: return {8'h00, a > b};
    endcase
  endfunction

  always_comb {alu_c_out, alu_out} = alu_fn(alu_a, alu_b, alu_opcode);

  function automatic exp_t exp_of(input logic [7:0] a, input logic [7:0] b,
                                  input logic [3:0] op);
    exp_t e;
    logic [8:0] r;
    if (op == 4'h9 && b == 8'h00) begin
      e = '{d: 8'hFF, c: 1'b0, z: 1'b0, v0: 1'b1};
    end else begin
      r = alu_fn(a, b, op);
      e = '{d: r[7:0], c: r[8], z: (r[7:0] == 8'h00), v0: 1'b0};
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // One clock: score the response handshake, track push/flush, then advance.
  task automatic cycle();
    exp_t e;
    #2;
    if (rsp_valid && rsp_ready) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      check("rsp_scoreboard", {rsp_data, rsp_carry, rsp_zero, rsp_div0}, e);
    end
    if (flush) exp_q.delete();
    else if (cmd_valid && cmd_ready) begin
      exp_q.push_back(exp_of(cmd_a, cmd_b, cmd_op));
      accepted++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
  endtask

  task automatic drain();
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle();
    check("drain_empty", exp_q.size(), 0);
    cycle();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_op = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp", {rsp_valid, rsp_data, rsp_carry, rsp_zero, rsp_div0}, 0);
    check("rst_count", fifo_count, 0);
    check("rst_alu", {alu_a, alu_b, alu_opcode}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADD latency and carry
    rsp_ready = 1'b1;
    drive(4'h6, 8'hF0, 8'h20);
    cycle();
    cmd_valid = 1'b0;
    check("add_lat_valid_n1", rsp_valid, 0);
    check("add_head_alu", {alu_a, alu_b, alu_opcode}, {8'hF0, 8'h20, 4'h6});
    cycle();
    check("add_lat_valid_n2", rsp_valid, 1);
    check("add_result", {rsp_data, rsp_carry, rsp_zero}, {8'h10, 1'b1, 1'b0});
    drain();

    // SUB then GT back to back
    drive(4'h7, 8'h05, 8'h05);
    cycle();
    drive(4'hF, 8'h07, 8'h03);
    cycle();
    cmd_valid = 1'b0;
    check("sub_zero", {rsp_valid, rsp_data, rsp_carry, rsp_zero}, {1'b1, 8'h00, 1'b0, 1'b1});
    cycle();
    check("gt_result", {rsp_valid, rsp_data}, {1'b1, 8'h01});
    drain();

    // Backpressure: 6 offered, 5 accepted
    rsp_ready = 1'b0;
    accepted  = 0;
    drive(4'h0, 8'h3C, 8'h0F); cycle();
    drive(4'h1, 8'h30, 8'h03); cycle();
    drive(4'h2, 8'hFF, 8'hFF); cycle();
    drive(4'h6, 8'h80, 8'h80); cycle();
    drive(4'h8, 8'h10, 8'h11); cycle();
    drive(4'hA, 8'h81, 8'h00); cycle();
    cmd_valid = 1'b0;
    check("stall_accepted", accepted, 5);
    check("stall_count", fifo_count, 4);
    check("stall_cmd_ready", cmd_ready, 0);
    for (int i = 0; i < 3; i++) begin
      check("stall_hold", {rsp_valid, rsp_data, rsp_carry}, {1'b1, exp_q[0].d, exp_q[0].c});
      cycle();
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("b2b_valid", rsp_valid, 1);
      cycle();
    end
    check("b2b_done", rsp_valid, 0);
    drain();

    // Divide override
    drive(4'h9, 8'h09, 8'h00);
    cycle();
    drive(4'h9, 8'h09, 8'h03);
    cycle();
    cmd_valid = 1'b0;
    check("div0_result", {rsp_data, rsp_carry, rsp_div0}, {8'hFF, 1'b0, 1'b1});
    cycle();
    check("div_result", {rsp_data, rsp_div0}, {8'h03, 1'b0});
    drain();

    // Flush with 3 queued plus a held result, and a same-cycle push
    rsp_ready = 1'b0;
    drive(4'h6, 8'h01, 8'h01); cycle();
    drive(4'h6, 8'h02, 8'h02); cycle();
    drive(4'h6, 8'h03, 8'h03); cycle();
    drive(4'h6, 8'h04, 8'h04); cycle();
    check("pre_flush_count", fifo_count, 3);
    drive(4'h6, 8'h05, 8'h05);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    cmd_valid = 1'b0;
    check("flush_state", {rsp_valid, fifo_count}, 0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("flush_no_output", {rsp_valid, fifo_count}, 0);
      cycle();
    end

    // Asynchronous reset in the middle of a cycle
    rsp_ready = 1'b0;
    drive(4'h1, 8'h11, 8'h22); cycle();
    drive(4'h1, 8'h33, 8'h44); cycle();
    drive(4'h1, 8'h55, 8'h66); cycle();
    cmd_valid = 1'b0;
    check("pre_rst_state", {rsp_valid, fifo_count}, {1'b1, 3'd2});
    #3 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("async_rst_rsp", {rsp_valid, rsp_data, rsp_carry, rsp_zero, rsp_div0}, 0);
    check("async_rst_count", {cmd_ready, fifo_count}, {1'b1, 3'd0});
    check("async_rst_alu", {alu_a, alu_b, alu_opcode}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rsp_ready = 1'b1;
    drive(4'h6, 8'h01, 8'h02);
    cycle();
    cmd_valid = 1'b0;
    check("post_rst_lat_n1", rsp_valid, 0);
    cycle();
    check("post_rst_result", {rsp_valid, rsp_data}, {1'b1, 8'h03});
    drain();
    check("post_rst_idle", {rsp_valid, fifo_count}, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_cmd_issue.md
# alu_cmd_issue

Command issue and result capture stage wrapped around the combinational 8-bit ALU. It accepts ALU commands (operands plus opcode) over a valid/ready handshake and buffers them in a small FIFO. It presents the FIFO head to the ALU, registers the ALU result together with status flags, and hands the result downstream over a second valid/ready handshake with full backpressure.

## Interface
- DEPTH, 4, command FIFO entries; power of two, minimum 2
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous; discards all queued commands and any held result
- cmd_valid  in  1  command present
- cmd_ready  out  1  command FIFO can accept
- cmd_a  in  8  operand A
- cmd_b  in  8  operand B
- cmd_op  in  4  ALU opcode
- alu_a  out  8  operand A to the ALU
- alu_b  out  8  operand B to the ALU
- alu_opcode  out  4  opcode to the ALU
- alu_out  in  8  ALU result
- alu_c_out  in  1  ALU carry / bit 8
- rsp_valid  out  1  result register holds a result
- rsp_ready  in  1  downstream accepts the result
- rsp_data  out  8  result
- rsp_carry  out  1  captured carry
- rsp_zero  out  1  rsp_data == 0
- rsp_div0  out  1  divide (4'b1001) issued with b == 0
- fifo_count  out  clog2(DEPTH)+1  occupied FIFO entries

## Operation
- Push: occurs when cmd_valid && cmd_ready. cmd_ready = (fifo_count < DEPTH). cmd_ready is registered-state-only and does not depend on a same-cycle pop, so a full FIFO never accepts, even while popping.
- ALU drive: alu_a, alu_b and alu_opcode equal the FIFO head when fifo_count > 0; otherwise they are all zero. The ALU is purely combinational.
- Result register FSM, states R_EMPTY and R_FULL:
  - R_EMPTY: if fifo_count > 0, capture the result, pop the head, and go to R_FULL.
  - R_FULL: if rsp_ready, the result is consumed. If fifo_count > 0 in the same cycle, capture and pop again and stay in R_FULL (back-to-back throughput of 1 per cycle). Otherwise go to R_EMPTY. If rsp_ready is low, hold all rsp_* outputs stable.
- Capture rules:
  - Normal case: rsp_data = alu_out, rsp_carry = alu_c_out.
  - Opcode 4'b1001 with head b == 8'h00: rsp_data = 8'hFF, rsp_carry = 0, rsp_div0 = 1. The ALU output is ignored in this case.
  - rsp_zero is computed from the final rsp_data value.
- Simultaneous push and pop on a non-full FIFO: fifo_count is unchanged and ordering is preserved.
- Flush:
  - Next state: FIFO empty, R_EMPTY, rsp_valid = 0.
  - A push in the same cycle is dropped.
  - Flush has priority over capture.
- Reset: asserting rst_n low mid-operation immediately clears the FIFO pointers, count and FSM. Nothing is replayed after reset.

## Timing
- Reset values: cmd_ready = 1, rsp_valid = 0, rsp_data = 8'h00, rsp_carry = 0, rsp_zero = 0, rsp_div0 = 0, fifo_count = 0, alu_* = 0.
- Latency into an empty block with rsp_ready = 1:
  - Command accepted at edge N.
  - Head visible to the ALU during cycle N+1.
  - Result captured at edge N+1; rsp_valid high from N+1 to N+2.
  - Total: 2 edges from acceptance to result.
- Sustained throughput is 1 result per cycle while rsp_ready = 1 and commands keep arriving.
- Maximum in-flight commands: DEPTH in the FIFO plus 1 in the result register.
- The FIFO pointers wrap modulo DEPTH. The count distinguishes full from empty.

## Structure
- Shared package alu_pkg holds:
  - Opcode localparams: OP_AND = 4'h0, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_XNOR, OP_ADD, OP_SUB, OP_MUL, OP_DIV = 4'h9, OP_SHL, OP_SHR, OP_ROR, OP_ROL, OP_EQ, OP_GT = 4'hF.
  - ALU_W = 8.
  - The command struct/typedef: a, b, op.
- One sub-module: alu_cmd_fifo. It is a synchronous FIFO parameterised on DEPTH and width (20 bits), with count, push, pop and flush. The top level holds the FSM, the div0 override and the flags.

## Test plan
- ADD a = 8'hF0, b = 8'h20, rsp_ready = 1 → rsp_valid 2 edges after acceptance; rsp_data = 8'h10, rsp_carry = 1, rsp_zero = 0.
- SUB a = 8'h05, b = 8'h05 → rsp_data = 8'h00, rsp_zero = 1, rsp_carry = 0. GT a = 8'h07, b = 8'h03 → rsp_data = 8'h01.
- Hold rsp_ready = 0 and push 6 commands:
  - 5 are accepted (1 in the result register plus 4 in the FIFO); fifo_count = 4 and cmd_ready = 0.
  - While stalled, the first result is held stable.
  - After raising rsp_ready, results emerge in order, one per cycle.
- DIV a = 8'h09, b = 8'h00 → rsp_data = 8'hFF, rsp_div0 = 1, rsp_carry = 0. DIV a = 8'h09, b = 8'h03 → rsp_data = 8'h03, rsp_div0 = 0.
- With 3 commands queued and a result held, pulse flush together with cmd_valid → next cycle fifo_count = 0, rsp_valid = 0, and the flushed commands and same-cycle push never appear.
- With a result held and the FIFO non-empty, assert rst_n low mid-cycle → outputs go to their reset values immediately. After release, the first new command's result returns with 2-edge latency.
